gray_updown: RTL and testbench
==============================

GRAY_UPDOWN -- requirements
Module: gray_updown

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, Gray counter width in bits; legal range 2..16.
REQ-002 The block SHALL have parameter STICKY, default 1: 1 = wrap flags hold until cleared; 0 = wrap flags are single-cycle pulses.
REQ-003 The block SHALL have port Clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port En  input  1  count enable; one step per Clk edge while high.
REQ-006 The block SHALL have port Dir  input  1  direction: 0 = up, 1 = down; sampled only when En is high.
REQ-007 The block SHALL have port Load  input  1  synchronous load strobe.
REQ-008 The block SHALL have port LoadVal  input  WIDTH  Gray-coded value to load.
REQ-009 The block SHALL have port ClrFlags  input  1  clears Overflow and Underflow; used only when STICKY=1.
REQ-010 The block SHALL have port Output  output  WIDTH  registered Gray-coded count.
REQ-011 The block SHALL have port Binary  output  WIDTH  registered binary equivalent of Output.
REQ-012 The block SHALL have port Overflow  output  1  up-count wrapped from the maximum code to zero.
REQ-013 The block SHALL have port Underflow  output  1  down-count wrapped from zero to the maximum code.

Function
REQ-014 Output SHALL always equal Binary ^ (Binary >> 1); both SHALL be registered and change only on a Clk edge.
REQ-015 Per-edge priority SHALL be: Reset > Load > En; with none asserted, count state SHALL hold.
REQ-016 Load SHALL convert LoadVal from Gray to binary and set Output to LoadVal on the same edge; En and Dir SHALL be ignored that cycle.
REQ-017 Load SHALL NOT alter Overflow or Underflow, except that in STICKY=0 mode both flags SHALL drop to 0 on any edge that does not wrap.
REQ-018 En=1, Dir=0 SHALL advance Binary by 1 modulo 2^WIDTH, so Output moves to the next Gray code; exactly one Output bit changes per step.
REQ-019 En=1, Dir=1 SHALL decrement Binary by 1 modulo 2^WIDTH; exactly one Output bit changes per step.
REQ-020 Up-step from Binary = 2^WIDTH-1 SHALL wrap to 0 and assert Overflow on that same edge.
REQ-021 Down-step from Binary = 0 SHALL wrap to 2^WIDTH-1 and assert Underflow on that same edge.
REQ-022 STICKY=1: each flag SHALL stay 1 until Reset, or an edge with ClrFlags=1 and no new wrap of that flag.
REQ-023 STICKY=1: a wrap and ClrFlags on the same edge SHALL leave the wrapped flag set; the other flag SHALL clear.
REQ-024 STICKY=0: a flag SHALL be 1 for exactly the one cycle after its wrap edge; ClrFlags SHALL be ignored.
REQ-025 Overflow and Underflow SHALL never be set by the same edge.
REQ-026 Dir changes mid-sequence SHALL take effect on the next enabled edge with no lost or duplicated step.
REQ-027 En held continuously SHALL wrap indefinitely; each wrap SHALL re-trigger the corresponding flag.

Reset
REQ-028 Reset=1 at a Clk edge SHALL force Output=0, Binary=0, Overflow=0, Underflow=0, overriding Load, En and ClrFlags.
REQ-029 Before the first Reset, the power-up (initial) state SHALL equal the reset state.
REQ-030 Reset asserted mid-count SHALL take effect on that edge; counting SHALL resume from 0 on the first edge after Reset deasserts with En=1.

Verification (WIDTH=3, STICKY=1 unless stated)
REQ-031 The bench SHALL reset, then drive En=1, Dir=0 for 8 edges -> Output 001,011,010,110,111,101,100,000; Overflow=1 after the 8th edge only.
REQ-032 The bench SHALL reset, then drive En=1, Dir=1 for 1 edge -> Output=100, Binary=7, Underflow=1, Overflow=0.
REQ-033 The bench SHALL drive Load=1, LoadVal=110 with En=1 -> Output=110, Binary=4; next up-step -> 111.
REQ-034 The bench SHALL start at Output=100 with Overflow=0 and drive En=1, Dir=0 plus ClrFlags=1 on the same edge -> Output=000 and Overflow=1 (set wins); an edge with ClrFlags alone -> Overflow=0.
REQ-035 With STICKY=0, the bench SHALL wrap up once -> Overflow=1 for exactly one cycle, then 0 while counting continues.
REQ-036 The bench SHALL assert Reset mid-count at Output=011 with En=1 -> Output=000, all flags 0; after release -> 001.

Source files
------------

// File: rtl/gray_updown.sv
// Up/down Gray-code counter with registered Gray and binary views and
// wrap flags that are either sticky (cleared by ClrFlags) or single-cycle pulses.
module gray_updown #(
  parameter int WIDTH  = 4,
  parameter bit STICKY = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [WIDTH-1:0] MAX_BIN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Initialisers give a power-up state identical to the reset state.
  logic [WIDTH-1:0] bin_q  = ZERO;
  logic [WIDTH-1:0] gray_q = ZERO;
  logic             ovf_q  = 1'b0;
  logic             unf_q  = 1'b0;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             ovf_d;
  logic             unf_d;
  logic             wrap_up_s;
  logic             wrap_dn_s;

  // Next-state: Reset over Load over En; flags derive from the wrap detect.
  always_comb begin
    bin_d     = bin_q;
    wrap_up_s = 1'b0;
    wrap_dn_s = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (Reset) begin
      bin_d = ZERO;
    end else if (Load) begin
      bin_d = gray2bin(LoadVal);
    end else if (En) begin
      if (Dir) begin
        bin_d     = bin_q - ONE;
        wrap_dn_s = (bin_q == ZERO);
      end else begin
        bin_d     = bin_q + ONE;
        wrap_up_s = (bin_q == MAX_BIN);
      end
    end else begin
      bin_d = bin_q;
    end

    if (Reset) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (STICKY) begin
      ovf_d = wrap_up_s | (ovf_q & ~ClrFlags);
      unf_d = wrap_dn_s | (unf_q & ~ClrFlags);
    end else begin
      ovf_d = wrap_up_s;
      unf_d = wrap_dn_s;
    end

    gray_d = bin2gray(bin_d);
  end

  // State registers; Gray is registered from the same next value as binary.
  always_ff @(posedge Clk) begin
    bin_q  <= bin_d;
    gray_q <= gray_d;
    ovf_q  <= ovf_d;
    unf_q  <= unf_d;
  end

  assign Output    = gray_q;
  assign Binary    = bin_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_gray_updown.sv
// Directed bench for gray_updown at WIDTH=3: a sticky instance and a
// pulse-flag instance share one set of stimulus.
module tb_gray_updown;

  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0;
  logic         Dir = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] LoadVal = 3'b000;
  logic         ClrFlags = 1'b0;

  logic [W-1:0] out_s, bin_s, out_p, bin_p;
  logic         ovf_s, unf_s, ovf_p, unf_p;

  int checks = 0;
  int failures = 0;

  gray_updown #(.WIDTH(W), .STICKY(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlags(ClrFlags),
    .Output(out_s), .Binary(bin_s), .Overflow(ovf_s), .Underflow(unf_s)
  );

  gray_updown #(.WIDTH(W), .STICKY(1'b0)) dut_pulse (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlags(ClrFlags),
    .Output(out_p), .Binary(bin_p), .Overflow(ovf_p), .Underflow(unf_p)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic rst, input logic en, input logic dir,
                       input logic ld, input logic [W-1:0] lv, input logic clr);
    Reset = rst; En = en; Dir = dir; Load = ld; LoadVal = lv; ClrFlags = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_s, bin_s, ovf_s, unf_s} !== 8'b0) begin
      failures++;
      $display("FAIL powerup: got out=%b bin=%0d ovf=%b unf=%b, want all 0", out_s, bin_s, ovf_s, unf_s);
    end
    // Reset must override Load and En.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
    tick();
    checks++;
    if ({out_s, bin_s, ovf_s, unf_s} !== 8'b0) begin
      failures++;
      $display("FAIL reset_override: got out=%b bin=%0d ovf=%b unf=%b, want all 0", out_s, bin_s, ovf_s, unf_s);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b000 || bin_s !== 3'd0) begin
      failures++;
      $display("FAIL hold_idle: got out=%b bin=%0d, want 000/0", out_s, bin_s);
    end
  endtask

  task automatic test_up_wrap();
    logic [W-1:0] exp_g [8];
    logic [W-1:0] exp_b [8];
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    exp_b = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_s !== exp_g[i] || bin_s !== exp_b[i] || ovf_s !== (i == 7) || unf_s !== 1'b0) begin
        failures++;
        $display("FAIL up_step%0d: got out=%b bin=%0d ovf=%b unf=%b, want out=%b bin=%0d ovf=%b unf=0",
                 i, out_s, bin_s, ovf_s, unf_s, exp_g[i], exp_b[i], (i == 7));
      end
    end
    // Continuing keeps the sticky flag while the pulse flag drops.
    tick();
    checks++;
    if (out_s !== 3'b001 || ovf_s !== 1'b1 || ovf_p !== 1'b0) begin
      failures++;
      $display("FAIL post_wrap: got out=%b ovf=%b ovf_pulse=%b, want 001 1 0", out_s, ovf_s, ovf_p);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b100 || bin_s !== 3'd7 || unf_s !== 1'b1 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL down_wrap: got out=%b bin=%0d unf=%b ovf=%b, want 100 7 1 0", out_s, bin_s, unf_s, ovf_s);
    end
    checks++;
    if (unf_p !== 1'b1 || ovf_p !== 1'b0) begin
      failures++;
      $display("FAIL down_wrap_pulse: got unf=%b ovf=%b, want 1 0", unf_p, ovf_p);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b101 || bin_s !== 3'd6 || unf_s !== 1'b1 || unf_p !== 1'b0) begin
      failures++;
      $display("FAIL down_step: got out=%b bin=%0d unf=%b unf_pulse=%b, want 101 6 1 0", out_s, bin_s, unf_s, unf_p);
    end
  endtask

  task automatic test_load();
    // Underflow is still set from the previous test; load must leave it.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b110 || bin_s !== 3'd4 || unf_s !== 1'b1) begin
      failures++;
      $display("FAIL load: got out=%b bin=%0d unf=%b, want 110 4 1", out_s, bin_s, unf_s);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b111 || bin_s !== 3'd5) begin
      failures++;
      $display("FAIL load_then_up: got out=%b bin=%0d, want 111 5", out_s, bin_s);
    end
  endtask

  task automatic test_clr_same_edge();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b100 || ovf_s !== 1'b0 || unf_s !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup: got out=%b ovf=%b unf=%b, want 100 0 1", out_s, ovf_s, unf_s);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    checks++;
    if (out_s !== 3'b000 || ovf_s !== 1'b1 || unf_s !== 1'b0) begin
      failures++;
      $display("FAIL wrap_beats_clr: got out=%b ovf=%b unf=%b, want 000 1 0", out_s, ovf_s, unf_s);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    checks++;
    if (out_s !== 3'b000 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone: got out=%b ovf=%b, want 000 0", out_s, ovf_s);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    checks++;
    if (out_s !== 3'b011) begin
      failures++;
      $display("FAIL mid_setup: got out=%b, want 011", out_s);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if ({out_s, bin_s, ovf_s, unf_s} !== 8'b0) begin
      failures++;
      $display("FAIL mid_reset: got out=%b bin=%0d ovf=%b unf=%b, want all 0", out_s, bin_s, ovf_s, unf_s);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b001 || bin_s !== 3'd1) begin
      failures++;
      $display("FAIL resume: got out=%b bin=%0d, want 001 1", out_s, bin_s);
    end
  endtask

  task automatic test_dir_change();
    // From binary 1: up, down, down, down crosses zero downward.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b001 || bin_s !== 3'd1) begin
      failures++;
      $display("FAIL dir_flip: got out=%b bin=%0d, want 001 1", out_s, bin_s);
    end
    tick();
    tick();
    checks++;
    if (out_s !== 3'b100 || bin_s !== 3'd7 || unf_s !== 1'b1 || ovf_s !== 1'b0) begin
      failures++;
      $display("FAIL dir_down_wrap: got out=%b bin=%0d unf=%b ovf=%b, want 100 7 1 0", out_s, bin_s, unf_s, ovf_s);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_s !== 3'b000 || ovf_s !== 1'b1 || unf_s !== 1'b1 || ovf_p !== 1'b1 || unf_p !== 1'b0) begin
      failures++;
      $display("FAIL dir_up_wrap: got out=%b ovf=%b unf=%b ovf_p=%b unf_p=%b, want 000 1 1 1 0",
               out_s, ovf_s, unf_s, ovf_p, unf_p);
    end
  endtask

  task automatic test_pulse_load();
    // Pulse mode: a non-wrapping load edge drops flags; ClrFlags ignored on wrap.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0);
    tick();
    checks++;
    if (out_p !== 3'b100 || ovf_p !== 1'b0 || ovf_s !== 1'b1) begin
      failures++;
      $display("FAIL pulse_load: got out_p=%b ovf_p=%b ovf_s=%b, want 100 0 1", out_p, ovf_p, ovf_s);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    checks++;
    if (out_p !== 3'b000 || ovf_p !== 1'b1 || unf_s !== 1'b0) begin
      failures++;
      $display("FAIL pulse_clr_ignored: got out_p=%b ovf_p=%b unf_s=%b, want 000 1 0", out_p, ovf_p, unf_s);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_clr_same_edge();
    test_reset_midcount();
    test_dir_change();
    test_pulse_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
